// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_OFF  : all segments dark (active-low)
//   SEG_PAT  : hex digit 0..F to {g,f,e,d,c,b,a} active-low pattern
//   scan_state_e : per-slot phase, GAP (all digits off) then DRIVE
//   cnt_width    : counter width for a modulus, never below 1
package hex_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Load interface for the scan controller.
//   load_valid : source offers load_data
//   load_ready : controller's pending buffer is empty
//   load_data  : nibble i is digit i, digit 0 rightmost
// master = value source, slave = hex_scan_ctrl.
interface hex_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/hex_scan_ctrl_seg_decode.sv
// Combinational hex to seven-segment decoder.
//   digit : 4-bit value 0..F
//   seg_n : {g,f,e,d,c,b,a}, active-low
module seg_decode
  import hex_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = SEG_PAT[digit];
  end
endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment display controller with double-buffered
// loads, leading-zero blanking, per-digit blink and an inter-digit gap.
//   clk, rst   : clock, asynchronous active-high reset
//   load_if    : valid/ready load of a full display value (slave side)
//   blank_lz   : leading-zero blanking enable (live)
//   blink_mask : per-digit blink enable (live)
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   dig_en     : digit enables, active-low, registered
//   frame_tick : one-cycle pulse after each frame boundary
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_scan_ctrl_if.slave        load_if,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W = cnt_width(SCAN_DIV);
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
  localparam int unsigned BLK_W = cnt_width(BLINK_FRAMES);
  localparam int unsigned DW    = 4 * NUM_DIGITS;

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  blk_ph_q, blk_ph_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  tick_q, tick_d;

  logic       last_cnt, last_idx, boundary;
  logic [3:0] cur_nib;
  logic       cur_blink, lz_blank;
  logic [6:0] dec_seg;

  seg_decode u_dec (
    .digit (cur_nib),
    .seg_n (dec_seg)
  );

  // Scan FSM: slot counter, digit index, frame boundary.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    last_cnt = (cnt_q == CNT_W'(SCAN_DIV - 1));
    last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = (state_q == DRIVE) && last_cnt && last_idx;
    case (state_q)
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = DRIVE;
      end
      DRIVE: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = GAP;
          idx_d   = last_idx ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = GAP;
    endcase
  end

  // Pending/display buffers and blink phase. Fill needs an empty buffer
  // and drain needs a full one, so the two never coincide.
  always_comb begin
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    blk_cnt_d   = blk_cnt_q;
    blk_ph_d    = blk_ph_q;
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (load_if.load_valid && !pend_full_q) begin
      pend_d      = load_if.load_data;
      pend_full_d = 1'b1;
    end
    if (boundary) begin
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        blk_ph_d  = ~blk_ph_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Current digit, suppression and registered outputs.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blink = 1'b0;
    lz_blank  = blank_lz && (idx_q != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib   = disp_q[4*i +: 4];
        cur_blink = blink_mask[i];
      end
      // Any nonzero nibble at or above the current index cancels blanking.
      if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'h0)) lz_blank = 1'b0;
    end
    seg_d    = SEG_OFF;
    dig_en_d = '1;
    if ((state_q == DRIVE) && !lz_blank && !(blk_ph_q && cur_blink)) begin
      seg_d    = dec_seg;
      dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GAP;
      cnt_q       <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      blk_ph_q    <= 1'b0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= SEG_OFF;
      dig_en_q    <= '1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_ph_q    <= blk_ph_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
      tick_q      <= tick_d;
    end
  end

  assign load_if.load_ready = !pend_full_q;
  assign seg                = seg_q;
  assign dig_en             = dig_en_q;
  assign frame_tick         = tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int GC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank_lz;
  logic [3:0] blink_mask;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       frame_tick;

  hex_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

  hex_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GAP_CYCLES   (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_if    (lif),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute cycle count since reset release plus buffers.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_empty;
  bit          m_acc;

  logic [6:0] pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t, cycle %0d)", tag, got, exp, $time, m_t);
    end
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_disp  = '0;
    m_pend  = '0;
    m_empty = 1'b1;
    m_acc   = 1'b0;
  endtask

  // Called just after a negedge with inputs stable; advances one clock.
  task automatic step();
    int          pos, dg, fr;
    bit          ph, off, et;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [6:0]  es;
    logic [3:0]  ed;
    pos   = m_t % SD;
    dg    = (m_t / SD) % ND;
    fr    = m_t / FRAME;
    ph    = ((fr / BF) % 2) == 1;
    upper = m_disp >> (4 * dg);
    nib   = upper[3:0];
    off   = (pos < GC);
    if (blank_lz && dg > 0 && upper == 16'h0) off = 1'b1;
    if (ph && blink_mask[dg]) off = 1'b1;
    es    = off ? 7'h7F : pat[nib];
    ed    = off ? 4'hF : ~(4'b0001 << dg);
    et    = (m_t % FRAME) == FRAME - 1;
    m_acc = lif.load_valid && m_empty;
    @(posedge clk);
    if (et && !m_empty) begin
      m_disp  = m_pend;
      m_empty = 1'b1;
    end else if (m_acc) begin
      m_pend  = lif.load_data;
      m_empty = 1'b0;
    end
    m_t++;
    @(negedge clk);
    check("seg", 32'(seg), 32'(es));
    check("dig_en", 32'(dig_en), 32'(ed));
    check("frame_tick", 32'(frame_tick), 32'(et));
    check("load_ready", 32'(lif.load_ready), 32'(m_empty));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [15:0] v);
    int n;
    n = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = v;
    do begin
      step();
      n++;
    end while (!m_acc && n < 4 * FRAME);
    lif.load_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    blank_lz       = 1'b1;
    blink_mask     = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dig_en", 32'(dig_en), 32'hF);
    check("rst_ready", 32'(lif.load_ready), 32'h1);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;

    // First frame with zero display and blanking on
    run(FRAME);

    // Plain load and display
    blank_lz = 1'b0;
    load(16'h12AF);
    run(2 * FRAME);

    // Back-to-back loads: second waits for the boundary drain
    load(16'h1111);
    load(16'h3333);
    run(2 * FRAME + 4);

    // Leading-zero blanking, then turned off mid-frame
    blank_lz = 1'b1;
    load(16'h0050);
    run(FRAME + FRAME / 2);
    blank_lz = 1'b0;
    run(FRAME);

    // Blink digit 0
    blink_mask = 4'b0001;
    run(5 * FRAME);
    blink_mask = 4'b0000;

    // Asynchronous reset mid-DRIVE with a load pending
    load(16'hA5C3);
    run(2 * FRAME);
    for (int i = 0; i < FRAME && (m_t % FRAME) != 2; i++) step();
    load(16'h7777);
    run(2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dig_en", 32'(dig_en), 32'hF);
    check("arst_ready", 32'(lif.load_ready), 32'h1);
    check("arst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(FRAME + 8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!lif.load_valid && $urandom_range(7) == 0) begin
        lif.load_valid = 1'b1;
        lif.load_data  = 16'($urandom);
      end
      if ($urandom_range(19) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(19) == 0) blink_mask = 4'($urandom);
      step();
      if (m_acc) lif.load_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
